// File: rtl/regs_dir_readback.sv
// Readback of the dir/OE control register bank: synchronises the asynchronous cfg_in bits, keeps a
// skew-filtered shadow copy, flags per-register changes and serves a request/ack read port.
module regs_dir_readback #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NUM_REGS    = 4
) (
   input  logic                  CLK,
   input  logic                  CLR,
   input  logic [NUM_REGS*8-1:0] cfg_in,
   input  logic                  rd_req,
   input  logic [1:0]            rd_addr,
   input  logic                  rd_ack,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic                  rd_busy,
   output logic [NUM_REGS-1:0]   chg_flags,
   input  logic [NUM_REGS-1:0]   irq_en,
   output logic                  irq
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VALID
   } state_t;

   state_t                state;
   logic [1:0]            addr;
   logic [NUM_REGS*8-1:0] sync_q [SYNC_STAGES];
   logic [NUM_REGS*8-1:0] s_q;
   logic [NUM_REGS*8-1:0] s_d;
   logic [7:0]            shadow [NUM_REGS];
   logic [NUM_REGS-1:0]   load_v;
   logic [NUM_REGS-1:0]   flags_nxt;

   assign s_q = sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         s_d <= '0;
      end else begin
         sync_q[0] <= cfg_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         s_d <= s_q;
      end
   end

   // A byte is accepted only once it has matched across two consecutive synchronised samples.
   always_comb begin
      load_v = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         load_v[i] = (s_q[i*8 +: 8] == s_d[i*8 +: 8]) && (s_q[i*8 +: 8] != shadow[i]);
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (load_v[i]) shadow[i] <= s_q[i*8 +: 8];
         end
      end
   end

   // Clear-on-read is applied first so a simultaneous shadow update keeps the flag set.
   always_comb begin
      flags_nxt = chg_flags;
      if (state == LOAD) flags_nxt[addr] = 1'b0;
      flags_nxt = flags_nxt | load_v;
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state     <= IDLE;
         addr      <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         rd_busy   <= 1'b0;
         chg_flags <= '0;
         irq       <= 1'b0;
      end else begin
         chg_flags <= flags_nxt;
         irq       <= |(chg_flags & irq_en);
         unique case (state)
            IDLE: begin
               if (rd_req) begin
                  addr    <= rd_addr;
                  rd_busy <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               rd_data  <= shadow[addr];
               rd_valid <= 1'b1;
               state    <= VALID;
            end
            VALID: begin
               if (rd_ack) begin
                  rd_valid <= 1'b0;
                  rd_busy  <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regs_dir_readback.sv
// Bench for regs_dir_readback: directed scenarios plus randomized traffic, every cycle compared
// against a sample-history reference model of the readback bank.
module tb_regs_dir_readback;

   localparam int unsigned SS = 2;

   logic        CLK = 1'b0;
   logic        CLR = 1'b1;
   logic [31:0] cfg_in = '0;
   logic        rd_req = 1'b0;
   logic [1:0]  rd_addr = '0;
   logic        rd_ack = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_busy;
   logic [3:0]  chg_flags;
   logic [3:0]  irq_en = '0;
   logic        irq;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   regs_dir_readback #(.SYNC_STAGES(SS), .NUM_REGS(4)) dut (
      .CLK(CLK), .CLR(CLR), .cfg_in(cfg_in), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
      .chg_flags(chg_flags), .irq_en(irq_en), .irq(irq)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: samp[j] is the cfg_in value taken j+1 edges ago.
   logic [31:0] samp [SS+1];
   logic [7:0]  m_shadow [4];
   logic [3:0]  m_flags, flags_n;
   logic        m_irq, irq_n;
   int          m_phase;   // 0 waiting, 1 fetching, 2 presenting
   logic [1:0]  m_addr;
   logic [7:0]  m_data;
   logic        m_valid, m_busy;

   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int j = 0; j <= SS; j++) samp[j] = '0;
         for (int b = 0; b < 4; b++) m_shadow[b] = '0;
         m_flags = '0; m_irq = 1'b0; m_phase = 0; m_addr = '0;
         m_data = '0; m_valid = 1'b0; m_busy = 1'b0;
      end else begin
         irq_n   = |(m_flags & irq_en);
         flags_n = m_flags;
         if (m_phase == 0) begin
            if (rd_req) begin m_addr = rd_addr; m_busy = 1'b1; m_phase = 1; end
         end else if (m_phase == 1) begin
            m_data = m_shadow[m_addr]; flags_n[m_addr] = 1'b0; m_valid = 1'b1; m_phase = 2;
         end else if (rd_ack) begin
            m_valid = 1'b0; m_busy = 1'b0; m_phase = 0;
         end
         for (int b = 0; b < 4; b++) begin
            if (samp[SS-1][b*8 +: 8] == samp[SS][b*8 +: 8] &&
                samp[SS-1][b*8 +: 8] != m_shadow[b]) begin
               m_shadow[b] = samp[SS-1][b*8 +: 8];
               flags_n[b]  = 1'b1;
            end
         end
         for (int j = SS; j > 0; j--) samp[j] = samp[j-1];
         samp[0] = cfg_in;
         m_flags = flags_n;
         m_irq   = irq_n;
      end
   end

   always @(negedge CLK) begin
      if (mon_en && !CLR) begin
         check("mdl_rd_data", rd_data, m_data);
         check("mdl_rd_valid", rd_valid, m_valid);
         check("mdl_rd_busy", rd_busy, m_busy);
         check("mdl_chg_flags", chg_flags, m_flags);
         check("mdl_irq", irq, m_irq);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Request driven right after edge N: LOAD after N+1, rd_valid after N+2.
   task automatic do_read(input logic [1:0] a, input int ack_wait, input logic [7:0] exp);
      rd_req = 1'b1; rd_addr = a;
      tick();
      rd_req = 1'b0;
      check("lat_valid_lo", rd_valid, 1'b0);
      check("lat_busy_load", rd_busy, 1'b1);
      tick();
      check("lat_valid_hi", rd_valid, 1'b1);
      check("rd_data", rd_data, exp);
      for (int i = 0; i < ack_wait; i++) begin
         tick();
         check("hold_valid", rd_valid, 1'b1);
         check("hold_data", rd_data, exp);
      end
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("ack_valid_lo", rd_valid, 1'b0);
      check("ack_busy_lo", rd_busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      CLR = 1'b0;
      mon_en = 1'b1;
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_busy", rd_busy, 1'b0);
      check("rst_chg_flags", chg_flags, 4'h0);
      check("rst_irq", irq, 1'b0);

      // Reset abort in the middle of VALID
      rd_req = 1'b1; rd_addr = 2'd1;
      tick(); rd_req = 1'b0;
      tick();
      check("abort_pre_valid", rd_valid, 1'b1);
      @(negedge CLK); #2;
      CLR = 1'b1;
      #1;
      check("abort_valid_async", rd_valid, 1'b0);
      check("abort_busy_async", rd_busy, 1'b0);
      check("abort_flags", chg_flags, 4'h0);
      @(negedge CLK); #1;
      CLR = 1'b0;
      tick();
      do_read(2'd0, 0, 8'h00);

      // Basic read with a delayed ack
      cfg_in[15:8] = 8'hA5;
      repeat (5) tick();
      do_read(2'd1, 4, 8'hA5);

      // Change detection and interrupt
      irq_en = 4'b0100;
      cfg_in[23:16] = 8'h3C;
      repeat (SS + 1) tick();
      check("chg_early", chg_flags[2], 1'b0);
      tick();
      check("chg_set", chg_flags[2], 1'b1);
      check("irq_lag", irq, 1'b0);
      tick();
      check("irq_set", irq, 1'b1);
      do_read(2'd2, 0, 8'h3C);
      check("chg_cleared", chg_flags[2], 1'b0);
      check("irq_cleared", irq, 1'b0);
      irq_en = 4'b0000;

      // Skew filter on reg0
      for (int i = 0; i < 10; i++) begin
         cfg_in[7:0] = (i % 2 == 0) ? 8'h0F : 8'hF0;
         tick();
      end
      check("skew_no_load", chg_flags[0], 1'b0);
      repeat (6) tick();
      check("skew_flag", chg_flags[0], 1'b1);
      do_read(2'd0, 1, 8'hF0);

      // Shadow update colliding with the LOAD edge
      cfg_in[31:24] = 8'h11;
      repeat (6) tick();
      do_read(2'd3, 0, 8'h11);
      cfg_in[31:24] = 8'h77;
      repeat (SS) tick();
      do_read(2'd3, 0, 8'h11);
      check("collide_flag", chg_flags[3], 1'b1);
      do_read(2'd3, 0, 8'h77);
      check("collide_flag_clr", chg_flags[3], 1'b0);

      // Stray ack in IDLE, held req through the transaction, req+ack together
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("stray_ack_busy", rd_busy, 1'b0);
      rd_req = 1'b1; rd_addr = 2'd1;
      tick();
      tick();
      check("proto_valid", rd_valid, 1'b1);
      check("proto_data", rd_data, 8'hA5);
      tick();
      rd_ack = 1'b1;
      tick();
      rd_req = 1'b0; rd_ack = 1'b0;
      check("proto_done_valid", rd_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("proto_no_requeue", rd_busy, 1'b0);
      end

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         int unsigned b;
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, 3);
            cfg_in[b*8 +: 8] = 8'($urandom);
         end
         rd_req  = ($urandom_range(0, 3) == 0);
         rd_addr = 2'($urandom);
         rd_ack  = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
         tick();
      end
      rd_req = 1'b0; rd_ack = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
